dpram_reader: RTL and testbench

DPRAM_READER -- requirements
Module: dpram_reader

---
 rtl/dpram_reader.sv | 131 +++++++++++++
 tb/tb_dpram_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_reader.sv
// Streams word_cnt words from a dual-port RAM read port into a small FIFO with a
// valid/ready output. Define DPRAM_READER_BYTESWAP_EN to byte-reverse each output word.
module dpram_reader #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 64,
    parameter int CNT_W      = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  word_cnt,
    output logic [ADDR_W-1:0] addrb,
    output logic              enb,
    input  logic [DATA_W-1:0] doutb,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state_reg, state_next;
    logic              done_reg, done_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [CNT_W-1:0]  remain_reg;
    logic              inflight_reg;
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [OCC_W-1:0]  count_reg;
    logic [OCC_W-1:0]  occupancy;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [DATA_W-1:0] head_word, out_word;
    logic              issue, push, pop, credit_ok;

    // A read is only issued when the FIFO is guaranteed room for its return.
    assign occupancy = count_reg + OCC_W'(inflight_reg);
    assign credit_ok = occupancy < OCC_W'(FIFO_DEPTH);
    assign push      = inflight_reg;
    assign pop       = m_valid & m_ready;

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start)
                    state_next = READ;
            end
            READ: begin
                if (remain_reg == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else if (credit_ok) begin
                    issue = 1'b1;
                    if (remain_reg == CNT_W'(1))
                        state_next = DRAIN;
                end
            end
            DRAIN: begin
                // All reads issued: the last word leaves when only one remains anywhere.
                if (pop && count_reg == OCC_W'(1) && !inflight_reg) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            done_reg     <= 1'b0;
            addr_reg     <= '0;
            remain_reg   <= '0;
            inflight_reg <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            done_reg     <= done_next;
            inflight_reg <= issue;
            if (state_reg == IDLE && start) begin
                addr_reg   <= start_addr;
                remain_reg <= word_cnt;
            end else if (issue) begin
                addr_reg   <= addr_reg + ADDR_W'(1);
                remain_reg <= remain_reg - CNT_W'(1);
            end
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + OCC_W'(1);
                2'b01:   count_reg <= count_reg - OCC_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wr_ptr_reg] <= doutb;
    end

    assign head_word = mem[rd_ptr_reg];

`ifdef DPRAM_READER_BYTESWAP_EN
    for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_swap
        assign out_word[gi*8 +: 8] = head_word[(DATA_W/8 - 1 - gi)*8 +: 8];
    end
`else
    assign out_word = head_word;
`endif

    assign m_valid = (count_reg != '0);
    assign m_data  = m_valid ? out_word : '0;
    assign addrb   = addr_reg;
    assign enb     = issue;
    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;

endmodule

// File: tb/tb_dpram_reader.sv
// Randomised scoreboard bench for dpram_reader: expected addresses and words are queued
// at each start from a RAM image, and a negedge monitor compares what the DUT presents.
module tb_dpram_reader;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 14;
    localparam int RAM_WORDS = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst, start, m_ready;
    logic [ADDR_W-1:0] start_addr, addrb;
    logic [CNT_W-1:0]  word_cnt;
    logic              enb, m_valid, busy, done;
    logic [DATA_W-1:0] doutb, m_data;

    logic [DATA_W-1:0] ram [RAM_WORDS];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [ADDR_W-1:0] exp_addr [$];
    logic [DATA_W-1:0] exp_data [$];
    int                pop_cyc  [$];
    int                enb_total = 0;
    int                pops_total = 0;
    int                done_total = 0;
    int                done_cyc = 0;
    int                first_valid_cyc = 0;
    bit                seen_valid = 0;
    bit                stall_prev = 0;
    logic [DATA_W-1:0] held_data = '0;
    logic [DATA_W-1:0] first_data = '0;

    dpram_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .word_cnt(word_cnt), .addrb(addrb), .enb(enb), .doutb(doutb),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM port B: data one clock after the enable.
    always @(posedge clk) begin
        if (enb)
            doutb <= ram[addrb];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_word(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
`ifdef DPRAM_READER_BYTESWAP_EN
        for (int b = 0; b < DATA_W / 8; b++)
            r[8*b +: 8] = w[8*(DATA_W/8 - 1 - b) +: 8];
`else
        r = w;
`endif
        return r;
    endfunction

    // Monitor: compares every read strobe and every accepted word against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (enb) begin
                enb_total++;
                if (exp_addr.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL enb_unexpected: got addrb=%0d expected no read", addrb);
                end else begin
                    check("addrb", 64'(addrb), 64'(exp_addr.pop_front()));
                end
            end
            if (m_valid && !seen_valid) begin
                seen_valid = 1;
                first_valid_cyc = cyc;
            end
            if (m_valid && stall_prev)
                check("m_data_hold", m_data, held_data);
            if (m_valid && m_ready) begin
                pops_total++;
                pop_cyc.push_back(cyc);
                if (pop_cyc.size() == 1)
                    first_data = m_data;
                if (exp_data.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL m_valid_unexpected: got m_data=%h expected no word", m_data);
                end else begin
                    check("m_data", m_data, exp_data.pop_front());
                end
            end
            stall_prev = m_valid && !m_ready;
            held_data  = m_data;
            if (done) begin
                done_total++;
                done_cyc = cyc;
            end
        end else begin
            stall_prev = 0;
        end
    end

    // mode 0: m_ready=1; mode 1: random m_ready; mode 2: 10-cycle stall plus an ignored start.
    task automatic run_xfer(input int addr, input int cnt, input int mode);
        int start_cyc, done_base, enb_base, budget;
        bit got_done;
        budget = 40 + cnt * 20;
        for (int i = 0; i < 50 && busy; i++) @(posedge clk) #1;
        check("idle_before_start", 64'(busy), 64'(0));
        pop_cyc.delete();
        seen_valid = 0;
        done_base  = done_total;
        enb_base   = enb_total;
        for (int i = 0; i < cnt; i++) begin
            exp_addr.push_back(ADDR_W'((addr + i) % RAM_WORDS));
            exp_data.push_back(model_word(ram[(addr + i) % RAM_WORDS]));
        end
        start      = 1;
        start_addr = ADDR_W'(addr);
        word_cnt   = CNT_W'(cnt);
        m_ready    = (mode == 2) ? 1'b0 : 1'b1;
        @(posedge clk) #1;
        start_cyc = cyc;
        start = 0;
        check("busy_after_start", 64'(busy), 64'(1));
        got_done = 0;
        for (int i = 0; i < budget && !got_done; i++) begin
            case (mode)
                1:       m_ready = ($urandom_range(0, 3) != 0);
                2:       m_ready = (i >= 9);
                default: m_ready = 1;
            endcase
            if (mode == 2 && i == 3) begin
                start = 1; start_addr = ADDR_W'(100); word_cnt = CNT_W'(5);
            end
            if (mode == 2 && i == 4)
                start = 0;
            @(posedge clk) #1;
            if (mode == 2 && i == 8)
                check("bp_enb_while_stalled", 64'(enb_total - enb_base), 64'(4));
            if (done) begin
                got_done = 1;
                check("busy_at_done", 64'(busy), 64'(0));
            end
        end
        if (!got_done) begin
            compared++;
            mismatched++;
            $display("FAIL done_timeout: got no done after %0d cycles expected a done pulse", budget);
        end
        m_ready = 1;
        @(posedge clk) #1;
        check("done_one_cycle", 64'(done), 64'(0));
        check("done_count", 64'(done_total - done_base), 64'(1));
        check("exp_data_left", 64'(exp_data.size()), 64'(0));
        check("exp_addr_left", 64'(exp_addr.size()), 64'(0));
        if (cnt == 0) begin
            check("zero_no_valid", 64'(seen_valid), 64'(0));
            check("zero_done_latency", 64'(done_cyc - start_cyc), 64'(1));
        end else if (mode == 0) begin
            check("first_valid_latency", 64'(first_valid_cyc - start_cyc), 64'(2));
            check("done_after_last", 64'(done_cyc - pop_cyc[pop_cyc.size()-1]), 64'(1));
            if (cnt >= 2)
                check("back_to_back", 64'(pop_cyc[1] - pop_cyc[0]), 64'(1));
        end
    endtask

    task automatic mid_reset;
        int base, i;
        exp_addr.delete();
        exp_data.delete();
        pop_cyc.delete();
        for (int k = 0; k < 8; k++) begin
            exp_addr.push_back(ADDR_W'(20 + k));
            exp_data.push_back(model_word(ram[20 + k]));
        end
        base = pops_total;
        m_ready = 1; start = 1; start_addr = ADDR_W'(20); word_cnt = CNT_W'(8);
        @(posedge clk) #1;
        start = 0;
        for (i = 0; i < 40 && (pops_total - base) < 3; i++) @(posedge clk) #1;
        check("mid_reset_pops", 64'(pops_total - base), 64'(3));
        rst = 1;
        @(posedge clk) #1;
        check("rst_mid_m_valid", 64'(m_valid), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_enb", 64'(enb), 64'(0));
        check("rst_mid_m_data", m_data, 64'(0));
        exp_addr.delete();
        exp_data.delete();
        rst = 0;
        repeat (3) @(posedge clk) #1;
        check("post_reset_valid", 64'(m_valid), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int a = 0; a < RAM_WORDS; a++)
            ram[a] = {$urandom(), $urandom()};
        ram[0] = 64'h0807060504030201;
        ram[1] = 64'h100F0E0D0C0B0A09;
        rst = 1; start = 0; m_ready = 1; start_addr = '0; word_cnt = '0;
        @(posedge clk) #1;
        start = 1; start_addr = ADDR_W'(7); word_cnt = CNT_W'(3);
        @(posedge clk) #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_enb", 64'(enb), 64'(0));
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_addrb", 64'(addrb), 64'(0));
        check("rst_m_data", m_data, 64'(0));
        rst = 0; start = 0;
        @(posedge clk) #1;
        check("start_during_rst_ignored", 64'(busy), 64'(0));

        run_xfer(0, 2, 0);
`ifdef DPRAM_READER_BYTESWAP_EN
        check("full_stream_word0", first_data, 64'h0102030405060708);
`else
        check("full_stream_word0", first_data, 64'h0807060504030201);
`endif
        run_xfer(40, 8, 2);
        run_xfer(8190, 4, 0);
        run_xfer(500, 0, 0);
        mid_reset();
        run_xfer(60, 6, 0);
        for (int t = 0; t < 14; t++) begin
            int addr, cnt;
            addr = ($urandom_range(0, 2) == 0) ? $urandom_range(8180, 8191) : $urandom_range(0, 8191);
            cnt  = $urandom_range(0, 20);
            run_xfer(addr, cnt, $urandom_range(0, 1));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
